pe_sequencer: RTL

- Command-driven controller sitting directly upstream of the 16-lane PE block.
- Accepts one macro-instruction at a time over a valid/ready handshake and expands it into the per-cycle PE control stream: BRAM addresses, write enables, the serial-ALU step counter, ALU select and the neighbour-shift direction strobes.
- Supports two instruction kinds:
  - bit-serial ALU operations over LENGTH-bit operands;
  - word-pair neighbour shifts that move data across the PE mesh.

---
 rtl/pe_sequencer_pkg.sv | 35 +++
 rtl/pe_seq_addr_gen.sv | 35 +++
 rtl/pe_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pe_sequencer_pkg.sv
// Shared definitions for the PE sequencer: op/direction codes, FSM states
// and the step-counter value shown while an ALU instruction retires.
package pe_sequencer_pkg;

    localparam int DEF_LENGTH  = 32;
    localparam int DEF_SHWORDS = 16;
    localparam int DEF_AW      = 10;
    localparam int IW          = 7;  // step index width; covers LENGTH and SHWORDS up to 127

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_ALU   = 2'd1,
        OP_SHIFT = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        DIR_E = 2'd0,
        DIR_W = 2'd1,
        DIR_S = 2'd2,
        DIR_N = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALU_RD = 3'd1,
        ALU_WR = 3'd2,
        SH_RD  = 3'd3,
        SH_WR  = 3'd4,
        FIN    = 3'd5
    } state_e;

    localparam logic [6:0] CNT_END = 7'(2 * DEF_LENGTH + 2);

endpackage

// File: rtl/pe_seq_addr_gen.sv
// BRAM address generation for the sequencer: base plus step-derived offset,
// wrapping silently modulo 2^AW.
module pe_seq_addr_gen
    import pe_sequencer_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          shift_mode,
    input  logic          wr_phase,
    input  logic [IW-1:0] step,
    input  logic [AW-1:0] srca,
    input  logic [AW-1:0] srcb,
    input  logic [AW-1:0] dst,
    output logic [AW-1:0] addra,
    output logic [AW-1:0] addrb
);

    logic [AW-1:0] off1;
    logic [AW-1:0] off2;

    assign off1 = AW'(step);
    assign off2 = AW'({step, 1'b0});

    always_comb begin
        if (shift_mode) begin
            // A SHIFT moves an even/odd word pair in place at the source base.
            addra = srca + off2;
            addrb = srca + off2 + AW'(1);
        end else begin
            addra = (wr_phase ? dst : srca) + off1;
            addrb = srcb + off1;
        end
    end

endmodule

// File: rtl/pe_sequencer.sv
// Macro-instruction sequencer: expands one accepted ALU/SHIFT/NOP command into
// the per-cycle PE control stream (addresses, write enables, step count, strobes).
module pe_sequencer
    import pe_sequencer_pkg::*;
#(
    parameter int LENGTH  = DEF_LENGTH,
    parameter int SHWORDS = DEF_SHWORDS,
    parameter int AW      = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [3:0]    cmd_alu_sel,
    input  logic [1:0]    cmd_dir,
    input  logic [AW-1:0] cmd_srca,
    input  logic [AW-1:0] cmd_srcb,
    input  logic [AW-1:0] cmd_dst,
    output logic          wea,
    output logic          web,
    output logic [AW-1:0] addra,
    output logic [AW-1:0] addrb,
    output logic [3:0]    alu_sel,
    output logic [6:0]    count,
    output logic          east,
    output logic          west,
    output logic          south,
    output logic          north,
    output logic          busy,
    output logic          done
);

    localparam logic [IW-1:0] LAST_K  = IW'(LENGTH - 1);
    localparam logic [IW-1:0] LAST_J  = IW'(SHWORDS - 1);
    // Retire count rescaled from the default-length constant when LENGTH is overridden.
    localparam logic [6:0]    FIN_CNT = CNT_END + 7'(2 * (LENGTH - DEF_LENGTH));

    state_e        state_reg, state_next;
    logic [IW-1:0] step_reg, step_next;
    logic [1:0]    op_reg;
    logic [1:0]    dir_reg;
    logic [3:0]    sel_reg;
    logic [AW-1:0] srca_reg, srcb_reg, dst_reg;

    logic          accept;
    logic          addr_valid;
    logic          sh_wr;
    logic [6:0]    step2;
    logic [AW-1:0] gen_a, gen_b;
    logic [3:0]    strobe;

    assign accept = cmd_valid & cmd_ready;
    assign step2  = 7'({step_reg, 1'b0});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            step_reg  <= '0;
            op_reg    <= OP_NOP;
            dir_reg   <= '0;
            sel_reg   <= '0;
            srca_reg  <= '0;
            srcb_reg  <= '0;
            dst_reg   <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            if (accept) begin
                op_reg   <= cmd_op;
                dir_reg  <= cmd_dir;
                sel_reg  <= cmd_alu_sel;
                srca_reg <= cmd_srca;
                srcb_reg <= cmd_srcb;
                dst_reg  <= cmd_dst;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        cmd_ready  = 1'b0;
        wea        = 1'b0;
        web        = 1'b0;
        count      = '0;
        done       = 1'b0;
        addr_valid = 1'b0;
        sh_wr      = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                step_next = '0;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_ALU:   state_next = ALU_RD;
                        OP_SHIFT: state_next = SH_RD;
                        default:  state_next = FIN;
                    endcase
                end
            end
            ALU_RD: begin
                addr_valid = 1'b1;
                count      = step2 + 7'd2;
                state_next = ALU_WR;
            end
            ALU_WR: begin
                addr_valid = 1'b1;
                wea        = 1'b1;
                count      = step2 + 7'd3;
                if (step_reg == LAST_K) begin
                    state_next = FIN;
                end else begin
                    state_next = ALU_RD;
                    step_next  = step_reg + IW'(1);
                end
            end
            SH_RD: begin
                addr_valid = 1'b1;
                state_next = SH_WR;
            end
            SH_WR: begin
                addr_valid = 1'b1;
                wea        = 1'b1;
                web        = 1'b1;
                sh_wr      = 1'b1;
                if (step_reg == LAST_J) begin
                    state_next = FIN;
                end else begin
                    state_next = SH_RD;
                    step_next  = step_reg + IW'(1);
                end
            end
            FIN: begin
                done       = 1'b1;
                count      = (op_reg == OP_ALU) ? FIN_CNT : 7'd0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    pe_seq_addr_gen #(.AW(AW)) u_addr_gen (
        .shift_mode (state_reg == SH_RD || state_reg == SH_WR),
        .wr_phase   (state_reg == ALU_WR),
        .step       (step_reg),
        .srca       (srca_reg),
        .srcb       (srcb_reg),
        .dst        (dst_reg),
        .addra      (gen_a),
        .addrb      (gen_b)
    );

    // Strobes only fire in SH_WR, where count is always 0.
    for (genvar gi = 0; gi < 4; gi++) begin : g_strobe
        assign strobe[gi] = sh_wr && (dir_reg == 2'(gi));
    end

    assign east    = strobe[DIR_E];
    assign west    = strobe[DIR_W];
    assign south   = strobe[DIR_S];
    assign north   = strobe[DIR_N];
    assign addra   = addr_valid ? gen_a : '0;
    assign addrb   = addr_valid ? gen_b : '0;
    assign alu_sel = sel_reg;
    assign busy    = (state_reg != IDLE);

endmodule
